// File: rtl/vga_overlay_ctrl.sv
// vga_overlay_ctrl: rectangle colour overlays with arbitrated write port, per-frame bank commit and registered hit test
//   Ports: CLK_100MHz/RESET_N (async active-low); CurrentX/CurrentY/VBlank/HBlank pixel timing;
//   REQ_VALID/REQ_READY/REQ_DATA0/REQ_DATA1 two-master config port; DIRTY, FRAME_CNT status;
//   yes/wRed/wGreen/wBlue overlay output. Optional blinking enabled by defining VGA_OVL_BLINK_EN.
module vga_overlay_ctrl #(
  parameter int NUM_RECT   = 4,
  parameter int BLINK_LOG2 = 5
) (
  input  logic        CLK_100MHz,
  input  logic        RESET_N,
  input  logic [10:0] CurrentX,
  input  logic [10:0] CurrentY,
  input  logic        VBlank,
  input  logic        HBlank,
  input  logic [1:0]  REQ_VALID,
  output logic [1:0]  REQ_READY,
  input  logic [63:0] REQ_DATA0,
  input  logic [63:0] REQ_DATA1,
  output logic        DIRTY,
  output logic [7:0]  FRAME_CNT,
  output logic        yes,
  output logic [3:0]  wRed,
  output logic [3:0]  wGreen,
  output logic [3:0]  wBlue
);
  if (NUM_RECT < 1 || NUM_RECT > 4 || BLINK_LOG2 < 0 || BLINK_LOG2 > 7) begin : g_bad_param
    $error("vga_overlay_ctrl: parameter out of range");
  end
  logic [63:0] pend_q [NUM_RECT];
  logic [63:0] act_q [NUM_RECT];
  logic ptr_q, ptr_d, vb_q, dirty_q, dirty_d, yes_q, yes_d;
  logic [7:0] frame_q, frame_d;
  logic [11:0] rgb_q, rgb_d;
  logic [1:0] gnt;
  logic xfer, sel, wok, commit;
  logic [63:0] wdata;
  logic [1:0] widx;
  logic [NUM_RECT-1:0] h;
  logic [NUM_RECT-1:0] unused_bits;
  // ptr_q holds the last winner; on contention the other master goes next
  assign gnt = !RESET_N ? 2'b00 : (&REQ_VALID) ? (ptr_q ? 2'b01 : 2'b10) : REQ_VALID;
  assign xfer = |gnt;
  assign sel = gnt[1];
  assign wdata = sel ? REQ_DATA1 : REQ_DATA0;
  assign widx = wdata[63:62];
  assign wok = xfer && (int'(widx) < NUM_RECT);
  assign commit = VBlank & ~vb_q;
  assign ptr_d = xfer ? sel : ptr_q;
  assign frame_d = commit ? frame_q + 8'd1 : frame_q;
  // a write on the commit edge still marks the pending bank as ahead of active
  assign dirty_d = wok ? 1'b1 : commit ? 1'b0 : dirty_q;
  for (genvar i = 0; i < NUM_RECT; i++) begin : g_hit
    assign h[i] = act_q[i][61]
      & (act_q[i][59:49] <= CurrentX) & (CurrentX <= act_q[i][37:27])
      & (act_q[i][48:38] <= CurrentY) & (CurrentY <= act_q[i][26:16])
`ifdef VGA_OVL_BLINK_EN
      & ~(act_q[i][60] & frame_q[BLINK_LOG2])
`endif
      ;
    assign unused_bits[i] = ^{act_q[i][63:62], act_q[i][60], act_q[i][15:12]};
  end
  always_comb begin
    yes_d = 1'b0;
    rgb_d = 12'h000;
    for (int i = NUM_RECT - 1; i >= 0; i--) begin
      yes_d = h[i] ? 1'b1 : yes_d;
      rgb_d = h[i] ? act_q[i][11:0] : rgb_d;
    end
  end
  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_RECT; i++) begin
        pend_q[i] <= '0;
        act_q[i] <= '0;
      end
      ptr_q <= 1'b0;
      vb_q <= 1'b0;
      dirty_q <= 1'b0;
      frame_q <= 8'd0;
      yes_q <= 1'b0;
      rgb_q <= 12'h000;
    end else begin
      for (int i = 0; i < NUM_RECT; i++) begin
        if (commit) act_q[i] <= pend_q[i];
        if (wok && widx == 2'(i)) pend_q[i] <= wdata;
      end
      ptr_q <= ptr_d;
      vb_q <= VBlank;
      dirty_q <= dirty_d;
      frame_q <= frame_d;
      yes_q <= yes_d & ~(VBlank | HBlank);
      rgb_q <= rgb_d;
    end
  end
  assign REQ_READY = gnt;
  assign DIRTY = dirty_q;
  assign FRAME_CNT = frame_q;
  assign yes = yes_q;
  assign {wRed, wGreen, wBlue} = rgb_q;
endmodule

// File: tb/tb_vga_overlay_ctrl.sv
// tb_vga_overlay_ctrl: directed self-checking bench for vga_overlay_ctrl
module tb_vga_overlay_ctrl;
`ifdef VGA_OVL_BLINK_EN
  localparam int BL = 1;
  localparam bit BLINK = 1'b1;
`else
  localparam int BL = 5;
  localparam bit BLINK = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, vblank = 1'b0, hblank = 1'b0;
  logic [10:0] x = '0, y = '0;
  logic [1:0] valid = 2'b11, ready;
  logic [63:0] d0 = '0, d1 = '0;
  logic dirty, yes;
  logic [7:0] frame;
  logic [3:0] r, g, b;
  int n_chk = 0, n_err = 0;
  logic [7:0] fr;
  vga_overlay_ctrl #(.NUM_RECT(3), .BLINK_LOG2(BL)) dut (
    .CLK_100MHz(clk), .RESET_N(rst_n), .CurrentX(x), .CurrentY(y),
    .VBlank(vblank), .HBlank(hblank), .REQ_VALID(valid), .REQ_READY(ready),
    .REQ_DATA0(d0), .REQ_DATA1(d1), .DIRTY(dirty), .FRAME_CNT(frame),
    .yes(yes), .wRed(r), .wGreen(g), .wBlue(b)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] rect(input logic [1:0] idx, input logic en, input logic bl,
      input int x0, input int y0, input int x1, input int y1, input logic [11:0] rgb);
    return {idx, en, bl, 11'(x0), 11'(y0), 11'(x1), 11'(y1), 4'h0, rgb};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [63:0] w);
    d0 = w;
    valid = 2'b01;
    #1 chk("wr_ready", 32'(ready), 32'h1);
    tick();
    valid = 2'b00;
  endtask
  task automatic commit();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    fr = fr + 8'd1;
    tick();
  endtask
  task automatic px(input string tag, input int px_x, input int px_y, input logic hb,
      input logic exp_yes, input logic [11:0] exp_rgb);
    x = 11'(px_x);
    y = 11'(px_y);
    hblank = hb;
    tick();
    chk({tag, "_yes"}, 32'(yes), 32'(exp_yes));
    if (exp_yes) chk({tag, "_rgb"}, {20'h0, r, g, b}, {20'h0, exp_rgb});
    hblank = 1'b0;
  endtask
  initial begin
    fr = 8'd0;
    #12;
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_yes", 32'(yes), 32'h0);
    chk("rst_frame", 32'(frame), 32'h0);
    chk("rst_dirty", 32'(dirty), 32'h0);
    #10 rst_n = 1'b1;
    valid = 2'b00;
    tick();
    px("idle", 50, 50, 1'b0, 1'b0, 12'h000);
    wr(rect(2'd0, 1'b1, 1'b0, 100, 100, 199, 149, 12'hF00));
    chk("dirty_set", 32'(dirty), 32'h1);
    px("precommit", 100, 100, 1'b0, 1'b0, 12'h000);
    commit();
    chk("frame1", 32'(frame), 32'h1);
    chk("dirty_clr", 32'(dirty), 32'h0);
    px("corner_tl", 100, 100, 1'b0, 1'b1, 12'hF00);
    px("corner_br", 199, 149, 1'b0, 1'b1, 12'hF00);
    px("x_past", 200, 100, 1'b0, 1'b0, 12'h000);
    px("y_past", 199, 150, 1'b0, 1'b0, 12'h000);
    px("hblank", 150, 120, 1'b1, 1'b0, 12'h000);
    wr(rect(2'd1, 1'b1, 1'b0, 0, 0, 799, 599, 12'h0F0));
    wr(rect(2'd2, 1'b1, 1'b0, 500, 0, 400, 599, 12'h00F));
    commit();
    px("ovl_r0", 150, 120, 1'b0, 1'b1, 12'hF00);
    px("ovl_r1", 10, 10, 1'b0, 1'b1, 12'h0F0);
    px("inverted", 450, 300, 1'b0, 1'b1, 12'h0F0);
    d0 = rect(2'd3, 1'b1, 1'b0, 0, 0, 10, 10, 12'hFFF);
    d1 = rect(2'd3, 1'b1, 1'b0, 0, 0, 10, 10, 12'hFFF);
    valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk("arb_both", 32'(ready), (i % 2 == 0) ? 32'h2 : 32'h1);
      tick();
    end
    valid = 2'b01;
    for (int i = 0; i < 2; i++) begin
      #1 chk("arb_m0", 32'(ready), 32'h1);
      tick();
    end
    valid = 2'b00;
    #1 chk("arb_none", 32'(ready), 32'h0);
    chk("badidx_dirty", 32'(dirty), 32'h0);
    vblank = 1'b1;
    d0 = rect(2'd0, 1'b1, 1'b0, 100, 100, 199, 149, 12'h00F);
    valid = 2'b01;
    tick();
    valid = 2'b00;
    vblank = 1'b0;
    fr = fr + 8'd1;
    chk("coll_frame", 32'(frame), 32'h3);
    chk("coll_dirty", 32'(dirty), 32'h1);
    px("coll_old", 150, 120, 1'b0, 1'b1, 12'hF00);
    commit();
    chk("coll_dirty2", 32'(dirty), 32'h0);
    px("coll_new", 150, 120, 1'b0, 1'b1, 12'h00F);
    for (int i = 0; i < 252; i++) commit();
    chk("wrap", 32'(frame), 32'h0);
    wr(rect(2'd0, 1'b1, 1'b1, 100, 100, 199, 149, 12'hF00));
    for (int i = 0; i < 4; i++) begin
      commit();
      px("blink", 150, 120, 1'b0, 1'b1, (BLINK && fr[BL]) ? 12'h0F0 : 12'hF00);
    end
    d0 = rect(2'd0, 1'b0, 1'b0, 0, 0, 0, 0, 12'h000);
    valid = 2'b01;
    rst_n = 1'b0;
    #1 chk("rst2_ready", 32'(ready), 32'h0);
    tick();
    rst_n = 1'b1;
    valid = 2'b00;
    chk("rst2_dirty", 32'(dirty), 32'h0);
    chk("rst2_frame", 32'(frame), 32'h0);
    commit();
    px("rst2_banks", 150, 120, 1'b0, 1'b0, 12'h000);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
